sda_to_par: RTL and testbench

Serial-to-parallel receiver directly downstream of the parallel-to-serial SDA transmitter. It watches the two-wire `scl`/`sda` link, detects a start condition and then shifts in `DATA_W` data bits MSB first. On the stop condition it presents the word on `data` with a one-cycle `valid` strobe. It runs on the same `sclk` as the transmitter and feeds the downstream parallel consumer (decoder or register file).

---
 rtl/sda_pkg.sv | 21 ++
 rtl/sda_edge_det.sv | 56 +++++
 rtl/sda_to_par.sv | 154 +++++++++++++++
 tb/tb_sda_to_par.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sda_pkg.sv
// ============================================================================
//  sda_pkg
//  Shared encodings and bus constants for the two-wire SDA link receivers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sda_pkg;

   localparam int   DATA_W_DEF = 4;
   localparam logic BUS_IDLE   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RECV      = 2'd1,
      ST_WAIT_STOP = 2'd2
   } sda_state_e;

endpackage

`default_nettype wire

// File: rtl/sda_edge_det.sv
// ============================================================================
//  sda_edge_det
//  Registers scl/sda and decodes start, stop and scl-rise events from the
//  current and previous samples. Reusable by any two-wire link monitor.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sda_edge_det
   import sda_pkg::*;
(
   input  logic sclk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic sda_r,
   output logic start_ev,
   output logic stop_ev,
   output logic rise_ev
);

   logic scl_r_q, scl_r_d;
   logic scl_p_q, scl_p_d;
   logic sda_r_q, sda_r_d;
   logic sda_p_q, sda_p_d;

   always_comb begin
      scl_r_d = scl;
      sda_r_d = sda;
      scl_p_d = scl_r_q;
      sda_p_d = sda_r_q;
   end

   // Reset to the idle-high bus level so release never looks like an event.
   always_ff @(posedge sclk) begin
      if (!rst) begin
         scl_r_q <= BUS_IDLE;
         scl_p_q <= BUS_IDLE;
         sda_r_q <= BUS_IDLE;
         sda_p_q <= BUS_IDLE;
      end else begin
         scl_r_q <= scl_r_d;
         scl_p_q <= scl_p_d;
         sda_r_q <= sda_r_d;
         sda_p_q <= sda_p_d;
      end
   end

   assign sda_r    = sda_r_q;
   assign start_ev = scl_p_q & scl_r_q & sda_p_q & ~sda_r_q;
   assign stop_ev  = scl_p_q & scl_r_q & ~sda_p_q & sda_r_q;
   assign rise_ev  = ~scl_p_q & scl_r_q;

endmodule

`default_nettype wire

// File: rtl/sda_to_par.sv
// ============================================================================
//  sda_to_par
//  Serial-to-parallel SDA receiver: start, DATA_W bits MSB first, stop.
//  Optional one-hot output enabled by macro SDA_TO_PAR_ONEHOT_OUT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sda_to_par
   import sda_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              sclk,
   input  logic              rst,
   input  logic              scl,
   input  logic              sda,
   output logic [DATA_W-1:0] data,
   output logic              valid,
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
   output logic              frame_err,
   output logic [(1<<DATA_W)-1:0] outhigh
`else
   output logic              frame_err
`endif
);

   localparam int              CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic start_ev;
   logic stop_ev;
   logic rise_ev;
   logic sda_r;

   sda_edge_det u_edge_det (
      .sclk     (sclk),
      .rst      (rst),
      .scl      (scl),
      .sda      (sda),
      .sda_r    (sda_r),
      .start_ev (start_ev),
      .stop_ev  (stop_ev),
      .rise_ev  (rise_ev)
   );

   sda_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              frame_err_q, frame_err_d;

`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
   localparam int OH_W = 1 << DATA_W;
   logic [OH_W-1:0] outhigh_q, outhigh_d;
`endif

   // Event priority is start > stop > rise in every state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_ev) begin
               state_d = ST_RECV;
               cnt_d   = '0;
            end
         end

         ST_RECV: begin
            if (start_ev) begin
               cnt_d       = '0;
               frame_err_d = 1'b1;
            end else if (stop_ev) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
            end else if (rise_ev) begin
               shreg_d = DATA_W'({shreg_q, sda_r});
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_WAIT_STOP;
               end
            end
         end

         ST_WAIT_STOP: begin
            if (start_ev) begin
               state_d     = ST_RECV;
               cnt_d       = '0;
               frame_err_d = 1'b1;
            end else if (stop_ev) begin
               state_d = ST_IDLE;
               data_d  = shreg_q;
               valid_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
   always_comb begin
      outhigh_d = outhigh_q;
      if (valid_d) begin
         outhigh_d = {{(OH_W-1){1'b0}}, 1'b1} << data_d;
      end
   end
`endif

   always_ff @(posedge sclk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
         outhigh_q   <= {{(OH_W-1){1'b0}}, 1'b1};
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
         outhigh_q   <= outhigh_d;
`endif
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
   assign outhigh   = outhigh_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sda_to_par.sv
// ============================================================================
//  tb_sda_to_par
//  Directed frames with a scoreboard of expected valid/frame_err pulses.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sda_to_par;

   localparam int DW = 4;

   logic          sclk = 1'b0;
   logic          rst  = 1'b0;
   logic          scl  = 1'b1;
   logic          sda  = 1'b1;
   logic [DW-1:0] data;
   logic          valid;
   logic          frame_err;
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
   logic [(1<<DW)-1:0] outhigh;
`endif

   sda_to_par #(.DATA_W(DW)) dut (
      .sclk      (sclk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .data      (data),
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
      .valid     (valid),
      .frame_err (frame_err),
      .outhigh   (outhigh)
`else
      .valid     (valid),
      .frame_err (frame_err)
`endif
   );

   always #5 sclk = ~sclk;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   always @(posedge sclk) cyc <= cyc + 1;

   typedef struct {
      bit            is_err;
      logic [DW-1:0] d;
      int            at;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] cur_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // The event is driven at a negedge: sampled on the next posedge (N),
   // reported on the one after (N+1).
   task automatic push_exp(input bit is_err, input logic [DW-1:0] d);
      exp_t e;
      e.is_err = is_err;
      e.d      = d;
      e.at     = cyc + 2;
      q.push_back(e);
   endtask

   // Monitor: pops an expectation whenever the DUT pulses an output.
   always @(posedge sclk) begin
      #1;
      if (valid === 1'b1 || frame_err === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: valid=%b frame_err=%b expected no pulse (cycle %0d)",
                     valid, frame_err, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
            chk("pulse_valid", {31'd0, valid}, {31'd0, !e.is_err});
            chk("pulse_latency", cyc, e.at);
            chk("pulse_data", {28'd0, data}, {28'd0, e.d});
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
            chk("pulse_outhigh", {16'd0, outhigh}, {16'd0, 16'h1 << e.d});
`endif
         end
      end
   end

   task automatic hold();
      repeat (2) @(negedge sclk);
   endtask

   task automatic send_start(input bit exp_err);
      sda = 1'b1; hold();
      scl = 1'b1; hold();
      sda = 1'b0;
      if (exp_err) push_exp(1'b1, cur_data);
      hold();
      scl = 1'b0; hold();
   endtask

   task automatic send_bit(input bit b);
      sda = b;    hold();
      scl = 1'b1; hold();
      scl = 1'b0; hold();
   endtask

   task automatic send_stop(input bit exp_err, input logic [DW-1:0] word);
      sda = 1'b0; hold();
      scl = 1'b1; hold();
      sda = 1'b1;
      if (exp_err) begin
         push_exp(1'b1, cur_data);
      end else begin
         cur_data = word;
         push_exp(1'b0, word);
      end
      hold();
   endtask

   task automatic send_frame(input logic [DW-1:0] word);
      send_start(1'b0);
      for (int i = DW - 1; i >= 0; i--) send_bit(word[i]);
      send_stop(1'b0, word);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge sclk);
      chk("reset_data", {28'd0, data}, 32'd0);
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
      chk("reset_outhigh", {16'd0, outhigh}, 32'h1);
`endif
      rst = 1'b1;

      // Idle bus with scl toggling must produce nothing.
      repeat (20) begin
         scl = ~scl;
         @(negedge sclk);
      end
      scl = 1'b1;
      hold();
      chk("idle_data", {28'd0, data}, 32'd0);

      send_frame(4'hA);
      hold();
      chk("frame_a_data", {28'd0, data}, 32'hA);
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
      chk("frame_a_outhigh", {16'd0, outhigh}, 32'h0400);
`endif

      send_frame(4'h3);
      send_frame(4'hF);
      hold();
      chk("b2b_data", {28'd0, data}, 32'hF);

      // Early stop after two bits.
      send_start(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_stop(1'b1, 4'h0);
      hold();
      chk("early_stop_data_hold", {28'd0, data}, 32'hF);
      send_frame(4'h5);
      hold();
      chk("after_err_data", {28'd0, data}, 32'h5);

      // Repeated start after three bits, then a clean frame.
      send_start(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_start(1'b1);
      for (int i = DW - 1; i >= 0; i--) send_bit(logic'((4'hC >> i) & 4'h1));
      send_stop(1'b0, 4'hC);
      hold();
      chk("rep_start_data", {28'd0, data}, 32'hC);

      // Reset mid-frame after two bits.
      send_start(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      rst = 1'b0;
      scl = 1'b1;
      sda = 1'b1;
      repeat (3) @(negedge sclk);
      chk("midreset_data", {28'd0, data}, 32'd0);
      chk("midreset_valid", {31'd0, valid}, 32'd0);
      chk("midreset_frame_err", {31'd0, frame_err}, 32'd0);
`ifdef SDA_TO_PAR_ONEHOT_OUT_EN
      chk("midreset_outhigh", {16'd0, outhigh}, 32'h1);
`endif
      cur_data = '0;
      rst = 1'b1;
      hold();
      send_frame(4'h9);
      hold();
      chk("post_reset_data", {28'd0, data}, 32'h9);

      repeat (10) @(negedge sclk);
      chk("scoreboard_empty", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
